// File: rtl/param_updown_counter.sv
// param_updown_counter: parametrised up/down counter with modulus, load, wrap/saturate mode and status flags.
// Single-edge design; tc is combinational so it can enable a higher cascade stage.
module param_updown_counter #(
    parameter int              WIDTH     = 4,
    parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             sat,
    output logic             ovf
);
    localparam logic [WIDTH-1:0] MAXV = MAX_COUNT[WIDTH-1:0];
    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d, sat_q, sat_d, ovf_q, ovf_d;
    logic             at_max, at_zero, at_bound;
    assign at_max   = q_q == MAXV;
    assign at_zero  = q_q == '0;
    assign at_bound = up_dn ? at_max : at_zero;
    assign tc       = en & at_bound;
    assign q        = q_q;
    assign wrap     = wrap_q;
    assign sat      = sat_q;
    assign ovf      = ovf_q;
    // Boundary is detected by compare, never by natural overflow, so any modulus works.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        sat_d  = sat_q;
        ovf_d  = ovf_q;
        if (load) begin
            q_d   = load_val > MAXV ? MAXV : load_val;
            sat_d = 1'b0;
            ovf_d = 1'b0;
        end else if (en) begin
            if (at_bound) begin
                ovf_d = 1'b1;
                if (SATURATE) begin
                    sat_d = 1'b1;
                end else begin
                    q_d    = up_dn ? '0 : MAXV;
                    wrap_d = 1'b1;
                end
            end else begin
                q_d   = up_dn ? q_q + 1'b1 : q_q - 1'b1;
                sat_d = 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            sat_q  <= sat_d;
            ovf_q  <= ovf_d;
        end
    end
endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: scoreboard bench over four configurations (default, mod-10 wrap, mod-10 saturate, cascade).
// Each step drives one DUT, others hold; expected results queue up and a monitor pops them per cycle.
module tb_param_updown_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic       r_v[4], ld_v[4], e_v[4], ud_v[4];
    logic [3:0] lv_v[4];
    logic [3:0] q_o[5];
    logic       tc_o[5], w_o[5], s_o[5], o_o[5];
    param_updown_counter #(.WIDTH(4)) u_a (
        .clk(clk), .reset(r_v[0]), .en(e_v[0]), .up_dn(ud_v[0]), .load(ld_v[0]), .load_val(lv_v[0]),
        .q(q_o[0]), .tc(tc_o[0]), .wrap(w_o[0]), .sat(s_o[0]), .ovf(o_o[0]));
    param_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) u_b (
        .clk(clk), .reset(r_v[1]), .en(e_v[1]), .up_dn(ud_v[1]), .load(ld_v[1]), .load_val(lv_v[1]),
        .q(q_o[1]), .tc(tc_o[1]), .wrap(w_o[1]), .sat(s_o[1]), .ovf(o_o[1]));
    param_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) u_c (
        .clk(clk), .reset(r_v[2]), .en(e_v[2]), .up_dn(ud_v[2]), .load(ld_v[2]), .load_val(lv_v[2]),
        .q(q_o[2]), .tc(tc_o[2]), .wrap(w_o[2]), .sat(s_o[2]), .ovf(o_o[2]));
    param_updown_counter #(.WIDTH(4)) u_lo (
        .clk(clk), .reset(r_v[3]), .en(e_v[3]), .up_dn(ud_v[3]), .load(ld_v[3]), .load_val(lv_v[3]),
        .q(q_o[3]), .tc(tc_o[3]), .wrap(w_o[3]), .sat(s_o[3]), .ovf(o_o[3]));
    param_updown_counter #(.WIDTH(4)) u_hi (
        .clk(clk), .reset(r_v[3]), .en(tc_o[3]), .up_dn(ud_v[3]), .load(ld_v[3]), .load_val(lv_v[3]),
        .q(q_o[4]), .tc(tc_o[4]), .wrap(w_o[4]), .sat(s_o[4]), .ovf(o_o[4]));
    typedef struct {
        int         sel;
        logic       tc;
        logic [7:0] q;
        logic       w, s, o;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    task automatic chk(input string name, input int sel, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut=%0d got %0h expected %0h at %0t", name, sel, act, exp, $time);
        end
    endtask
    task automatic step(input int s, input logic r, input logic ld, input logic [3:0] lv, input logic e,
                        input logic ud, input logic etc, input logic [7:0] eq, input logic ew,
                        input logic es, input logic eo);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            r_v[k] = 1'b0; ld_v[k] = 1'b0; e_v[k] = 1'b0; ud_v[k] = 1'b0; lv_v[k] = 4'd0;
        end
        r_v[s] = r; ld_v[s] = ld; lv_v[s] = lv; e_v[s] = e; ud_v[s] = ud;
        sb.push_back('{s, etc, eq, ew, es, eo});
    endtask
    // tc is judged against the pre-edge count and current inputs; the rest after the edge.
    initial begin
        exp_t it;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() != 0) begin
                it = sb[0];
                chk("tc", it.sel, {7'd0, tc_o[it.sel]}, {7'd0, it.tc});
                @(posedge clk);
                #1;
                chk("q", it.sel, it.sel == 3 ? {q_o[4], q_o[3]} : {4'd0, q_o[it.sel]}, it.q);
                chk("wrap", it.sel, {7'd0, w_o[it.sel]}, {7'd0, it.w});
                chk("sat", it.sel, {7'd0, s_o[it.sel]}, {7'd0, it.s});
                chk("ovf", it.sel, {7'd0, o_o[it.sel]}, {7'd0, it.o});
                void'(sb.pop_front());
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    initial begin
        for (int k = 0; k < 4; k++) begin
            r_v[k] = 1'b1; ld_v[k] = 1'b0; e_v[k] = 1'b0; ud_v[k] = 1'b0; lv_v[k] = 4'd0;
        end
        // default config: full-range up count with wrap
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            step(0, 0, 0, 0, 1, 1, i == 15, 8'((i + 1) % 16), i == 15, 0, i >= 15);
        step(0, 0, 0, 0, 1, 1, 0, 5, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1, 0, 6, 0, 0, 1);
        step(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0, 2, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0, 3, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0, 4, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0, 4, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0);
        // priority: reset over load over en
        step(0, 1, 1, 5, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 5, 1, 1, 0, 5, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 0, 1, 0, 5, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 1, 15, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 15, 0, 0, 1);
        // modulus 10, wrap mode
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 2, 0, 0, 0, 2, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 1, 9, 1, 0, 1);
        step(1, 0, 0, 0, 1, 0, 0, 8, 0, 0, 1);
        step(1, 0, 1, 12, 1, 1, 0, 9, 0, 0, 0);
        step(1, 0, 1, 15, 1, 1, 1, 9, 0, 0, 0);
        step(1, 0, 0, 0, 1, 1, 1, 0, 1, 0, 1);
        // modulus 10, saturate mode
        step(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(2, 0, 1, 7, 0, 0, 0, 7, 0, 0, 0);
        step(2, 0, 0, 0, 1, 1, 0, 8, 0, 0, 0);
        step(2, 0, 0, 0, 1, 1, 0, 9, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step(2, 0, 0, 0, 1, 1, 1, 9, 0, 1, 1);
        step(2, 0, 0, 0, 0, 1, 0, 9, 0, 1, 1);
        step(2, 0, 0, 0, 1, 0, 0, 8, 0, 0, 1);
        step(2, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        step(2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(2, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1);
        // cascade: upper stage enabled by lower tc
        step(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++)
            step(3, 0, 0, 0, 1, 1, i % 16 == 15, 8'(i + 1), (i + 1) % 16 == 0, 0, i >= 15);
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
